// File: rtl/mio_wait_mem.sv
// mio_wait_mem: word-addressed memory slave for the multi-cycle CPU bus.
// A request is accepted in IDLE, waits WAIT_CYCLES cycles and completes
// with a one-cycle MIO_ready pulse. Bad addresses (misaligned or out of range)
// complete one cycle after acceptance and flag addr_err. Dropping CPU_MIO
// during the wait aborts the request with no access and no MIO_ready.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   CPU_MIO             request valid, held by the CPU until MIO_ready
//   mem_w               1 = write, 0 = read (latched at acceptance)
//   Addr_in             byte address, word index = Addr_in[DEPTH_LOG2+1:2]
//   Data_wr             write data (latched at acceptance)
//   Data_rd             read data, updated only by good reads
//   MIO_ready           one-cycle completion pulse
//   addr_err            bad-request flag, only valid with MIO_ready
//   busy                request accepted and not yet completed
module mio_wait_mem #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [ADDR_W-1:0] Addr_in,
  input  logic [DATA_W-1:0] Data_wr,
  output logic [DATA_W-1:0] Data_rd,
  output logic              MIO_ready,
  output logic              addr_err,
  output logic              busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 255) begin : g_bad_wait
    $error("mio_wait_mem: WAIT_CYCLES must be in 0..255");
  end
  if (ADDR_W <= DEPTH_LOG2 + 2) begin : g_bad_addr
    $error("mio_wait_mem: ADDR_W must exceed DEPTH_LOG2+2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    busy_n, ready_n, err_n;
  logic                    was_done;
  logic                    wr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       data_q;
  logic                    latch;

  // Access port: in the zero-wait case the access happens on the acceptance
  // edge itself, so it must use the live inputs rather than the latches.
  logic                    acc, acc_wr;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [DATA_W-1:0]       acc_data;

  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic [DEPTH_LOG2-1:0] in_idx;
  logic                  in_bad;
  assign in_idx = Addr_in[DEPTH_LOG2+1:2];
  assign in_bad = (|Addr_in[1:0]) || (|(Addr_in >> (DEPTH_LOG2 + 2)));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    busy_n   = busy;
    ready_n  = 1'b0;
    err_n    = 1'b0;
    latch    = 1'b0;
    acc      = 1'b0;
    acc_wr   = wr_q;
    acc_idx  = idx_q;
    acc_data = data_q;
    case (state)
      IDLE: begin
        // The cycle right after a completion is skipped so a CPU_MIO still
        // held from the finished request is not taken as a new one.
        if (CPU_MIO && !was_done) begin
          latch  = 1'b1;
          busy_n = 1'b1;
          if (in_bad) begin
            state_n = DONE;
            ready_n = 1'b1;
            err_n   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            state_n  = DONE;
            ready_n  = 1'b1;
            acc      = 1'b1;
            acc_wr   = mem_w;
            acc_idx  = in_idx;
            acc_data = Data_wr;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (!CPU_MIO) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (cnt == 8'd0) begin
          state_n = DONE;
          ready_n = 1'b1;
          acc     = 1'b1;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      busy      <= 1'b0;
      MIO_ready <= 1'b0;
      addr_err  <= 1'b0;
      was_done  <= 1'b0;
      Data_rd   <= '0;
      wr_q      <= 1'b0;
      idx_q     <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      MIO_ready <= ready_n;
      addr_err  <= err_n;
      was_done  <= (state == DONE);
      if (latch) begin
        wr_q   <= mem_w;
        idx_q  <= in_idx;
        data_q <= Data_wr;
      end
      if (acc && !acc_wr) Data_rd <= mem[acc_idx];
    end
  end

  // Memory contents survive reset; only the commit is gated by it.
  always_ff @(posedge clk) begin
    if (!reset && acc && acc_wr) mem[acc_idx] <= acc_data;
  end

endmodule
